// File: rtl/pifo_enqueue_agent.sv
`default_nettype none
// ============================================================================
// Module      : pifo_enqueue_agent
// Description : Admission stage in front of the PIFO output queue. The whole
//               packet is admitted or dropped based on the first beat.
//               Optional packet counters: define ENQ_AGENT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pifo_enqueue_agent #(
    parameter int DATA_WIDTH        = 256,
    parameter int TUSER_WIDTH       = 128,
    parameter int RANK_WIDTH        = 32,
    parameter int BUFFER_ADDR_WIDTH = 12,
    parameter int BUFFER_WORD_DEPTH = 20,
    parameter int SLACK_WORDS       = 2
) (
    input  logic                      axis_aclk,
    input  logic                      axis_reset,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [RANK_WIDTH-1:0]     s_axis_tpifo,
    output logic                      s_axis_tready,
    input  logic                      s_is_buffer_almost_full,
    input  logic                      s_is_pifo_full,
    input  logic [BUFFER_ADDR_WIDTH-1:0] s_buffer_counter,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic [RANK_WIDTH-1:0]     m_axis_tpifo,
    output logic                      m_axis_buffer_wr_en,
    output logic                      m_axis_pifo_insert_en,
    output logic [31:0]               stat_pass_pkts,
    output logic [31:0]               stat_drop_pkts
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_PASS = 2'd1;
    localparam logic [1:0] C_DROP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_tready;
    logic        w_accept;
    logic        w_first;
    logic        w_admit;
    logic        w_fwd;
    logic [15:0] w_len;
    logic [16:0] w_words;
    logic [17:0] w_need;

    assign s_axis_tready = r_tready;
    assign w_accept      = s_axis_tvalid && r_tready;
    assign w_first       = (r_state == C_IDLE);

    // A zero-length packet still occupies one buffer word.
    always_comb begin
        w_len   = s_axis_tuser[15:0];
        w_words = (w_len == 16'd0) ? 17'd1 : (({1'b0, w_len} + 17'd31) >> 5);
        w_need  = 18'(s_buffer_counter) + {1'b0, w_words} + 18'(SLACK_WORDS);
        w_admit = !s_is_buffer_almost_full && !s_is_pifo_full &&
                  (w_need <= 18'(BUFFER_WORD_DEPTH));
    end

    assign w_fwd = w_accept && (w_first ? w_admit : (r_state == C_PASS));

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                C_IDLE: begin
                    if (!s_axis_tlast) w_state_nxt = w_admit ? C_PASS : C_DROP;
                end
                C_PASS, C_DROP: begin
                    if (s_axis_tlast) w_state_nxt = C_IDLE;
                end
                default: w_state_nxt = C_IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_state               <= C_IDLE;
            r_tready              <= 1'b0;
            m_axis_tvalid         <= 1'b0;
            m_axis_tlast          <= 1'b0;
            m_axis_tdata          <= '0;
            m_axis_tkeep          <= '0;
            m_axis_tuser          <= '0;
            m_axis_tpifo          <= '0;
            m_axis_buffer_wr_en   <= 1'b0;
            m_axis_pifo_insert_en <= 1'b0;
        end else begin
            r_state               <= w_state_nxt;
            r_tready              <= 1'b1;
            m_axis_tvalid         <= w_fwd;
            m_axis_tlast          <= w_fwd && s_axis_tlast;
            m_axis_tdata          <= w_fwd ? s_axis_tdata : '0;
            m_axis_tkeep          <= w_fwd ? s_axis_tkeep : '0;
            m_axis_tuser          <= w_fwd ? s_axis_tuser : '0;
            m_axis_tpifo          <= w_fwd ? s_axis_tpifo : '0;
            m_axis_buffer_wr_en   <= w_fwd;
            m_axis_pifo_insert_en <= w_fwd && w_first;
        end
    end

`ifdef ENQ_AGENT_STATS_EN
    logic [31:0] r_pass_pkts;
    logic [31:0] r_drop_pkts;

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_pass_pkts <= '0;
            r_drop_pkts <= '0;
        end else if (w_accept && w_first) begin
            if (w_admit) begin
                if (r_pass_pkts != 32'hFFFF_FFFF) r_pass_pkts <= r_pass_pkts + 32'd1;
            end else begin
                if (r_drop_pkts != 32'hFFFF_FFFF) r_drop_pkts <= r_drop_pkts + 32'd1;
            end
        end
    end

    assign stat_pass_pkts = r_pass_pkts;
    assign stat_drop_pkts = r_drop_pkts;
`else
    assign stat_pass_pkts = 32'd0;
    assign stat_drop_pkts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pifo_enqueue_agent.sv
`default_nettype none
// Table-driven bench for pifo_enqueue_agent: one record per clock cycle with
// the inputs of that cycle and the outputs expected right after its edge.
module tb_pifo_enqueue_agent;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_tvalid, s_tlast, s_tready;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic [127:0] s_tuser;
    logic [31:0]  s_tpifo;
    logic         af, pf;
    logic [11:0]  cnt;
    logic         m_tvalid, m_tlast, m_wr_en, m_ins;
    logic [255:0] m_tdata;
    logic [31:0]  m_tkeep;
    logic [127:0] m_tuser;
    logic [31:0]  m_tpifo;
    logic [31:0]  st_pass, st_drop;

    int checks = 0;
    int errors = 0;
    int exp_pass = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    pifo_enqueue_agent dut (
        .axis_aclk(clk), .axis_reset(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tuser(s_tuser), .s_axis_tpifo(s_tpifo),
        .s_axis_tready(s_tready),
        .s_is_buffer_almost_full(af), .s_is_pifo_full(pf),
        .s_buffer_counter(cnt),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tuser(m_tuser), .m_axis_tpifo(m_tpifo),
        .m_axis_buffer_wr_en(m_wr_en), .m_axis_pifo_insert_en(m_ins),
        .stat_pass_pkts(st_pass), .stat_drop_pkts(st_drop)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic        l;
        logic [15:0] len;
        logic [31:0] rank;
        logic [11:0] cnt;
        logic        af;
        logic        pf;
        logic [7:0]  dat;
        logic        ev;    // expected forwarded beat
        logic        el;    // expected tlast
        logic        ei;    // expected pifo insert
        logic        rdy;   // expected tready
        logic        first; // first beat of a packet
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, v, l, input int len, rank, c,
                                input logic a, p, input int dat,
                                input logic ev, el, ei, rdy, first);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.len = 16'(len); t.rank = 32'(rank);
        t.cnt = 12'(c); t.af = a; t.pf = p; t.dat = 8'(dat);
        t.ev = ev; t.el = el; t.ei = ei; t.rdy = rdy; t.first = first;
        return t;
    endfunction

    task automatic check(input string name, input logic [255:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        rst      = t.rst;
        s_tvalid = t.v;
        s_tlast  = t.l;
        s_tdata  = {248'd0, t.dat};
        s_tkeep  = '1;
        s_tuser  = {112'd0, t.len};
        s_tpifo  = t.rank;
        cnt      = t.cnt;
        af       = t.af;
        pf       = t.pf;
        @(posedge clk);
        #1;
        check($sformatf("ctrl[%0d] {v,l,wr,ins,rdy}", idx),
              256'({m_tvalid, m_tlast, m_wr_en, m_ins, s_tready}),
              256'({t.ev, t.el, t.ev, t.ei, t.rdy}));
        if (t.ev) begin
            check($sformatf("data[%0d]", idx), m_tdata, {248'd0, t.dat});
            check($sformatf("tuser[%0d]", idx), 256'(m_tuser[15:0]), 256'(t.len));
            check($sformatf("tkeep[%0d]", idx), 256'(m_tkeep), 256'(32'hFFFF_FFFF));
        end
        if (t.ei) check($sformatf("tpifo[%0d]", idx), 256'(m_tpifo), 256'(t.rank));
        if (t.rst) begin
            exp_pass = 0;
            exp_drop = 0;
        end else if (t.first) begin
            if (t.ei) exp_pass++;
            else      exp_drop++;
        end
    endtask

    task automatic check_stats(input string name);
`ifdef ENQ_AGENT_STATS_EN
        check({name, " pass"}, 256'(st_pass), 256'(exp_pass));
        check({name, " drop"}, 256'(st_drop), 256'(exp_drop));
`else
        check({name, " pass"}, 256'(st_pass), 256'd0);
        check({name, " drop"}, 256'(st_drop), 256'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
        s_tuser = '0; s_tpifo = '0; cnt = '0; af = 1'b0; pf = 1'b0;

        //           rst v l len rank cnt af pf dat   ev el ei rdy first
        tbl.push_back(mk(1,0,0,  0, 0,  0, 0,0,'h00, 0,0,0,0,0));
        tbl.push_back(mk(1,0,0,  0, 0,  0, 0,0,'h00, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,  0, 0,  0, 0,0,'h00, 0,0,0,1,0));
        // empty queue, 3 beats, len 80, rank 5
        tbl.push_back(mk(0,1,0, 80, 5,  0, 0,0,'h10, 1,0,1,1,1));
        tbl.push_back(mk(0,1,0, 80, 0,  0, 0,0,'h11, 1,0,0,1,0));
        tbl.push_back(mk(0,1,1, 80, 0,  0, 0,0,'h12, 1,1,0,1,0));
        // 15+3+2=20 admitted; status going bad mid-packet is ignored
        tbl.push_back(mk(0,1,0, 96, 7, 15, 0,0,'h20, 1,0,1,1,1));
        tbl.push_back(mk(0,1,0, 96, 0, 19, 1,1,'h21, 1,0,0,1,0));
        tbl.push_back(mk(0,1,1, 96, 0, 19, 1,1,'h22, 1,1,0,1,0));
        // 16+3+2=21 dropped; status clearing mid-packet is ignored
        tbl.push_back(mk(0,1,0, 96, 8, 16, 0,0,'h23, 0,0,0,1,1));
        tbl.push_back(mk(0,1,0, 96, 0,  0, 0,0,'h24, 0,0,0,1,0));
        tbl.push_back(mk(0,1,1, 96, 0,  0, 0,0,'h25, 0,0,0,1,0));
        // pifo full on first beat only -> dropped; next admitted with no gap
        tbl.push_back(mk(0,1,0, 64, 9,  0, 0,1,'h26, 0,0,0,1,1));
        tbl.push_back(mk(0,1,1, 64, 0,  0, 0,0,'h27, 0,0,0,1,0));
        tbl.push_back(mk(0,1,0, 64, 3,  0, 0,0,'h30, 1,0,1,1,1));
        tbl.push_back(mk(0,0,0,  0, 0,  0, 0,0,'h00, 0,0,0,1,0));
        tbl.push_back(mk(0,1,1, 64, 0,  0, 0,0,'h31, 1,1,0,1,0));
        // single-beat packets back to back
        tbl.push_back(mk(0,1,1,  0, 4, 17, 0,0,'h40, 1,1,1,1,1));
        tbl.push_back(mk(0,1,1, 32, 6,  0, 0,0,'h41, 1,1,1,1,1));
        tbl.push_back(mk(0,1,1, 32, 2,  0, 1,0,'h42, 0,0,0,1,1));
        tbl.push_back(mk(0,1,1, 33, 1, 16, 0,0,'h43, 1,1,1,1,1));
        tbl.push_back(mk(0,1,1, 33, 1, 17, 0,0,'h44, 0,0,0,1,1));

        foreach (tbl[i]) apply(tbl[i], i);
        check_stats("stats after table");

        // reset on beat 1 of a 4-beat admitted packet
        apply(mk(0,1,0,128,11,  0, 0,0,'h50, 1,0,1,1,1), 100);
        check_stats("stats before reset");
        apply(mk(1,1,0,128, 0,  0, 0,0,'h51, 0,0,0,0,0), 101);
        check_stats("stats after reset");
        apply(mk(0,0,0,  0, 0,  0, 0,0,'h00, 0,0,0,1,0), 102);
        // fresh decision from IDLE: a stale PASS state would forward this
        apply(mk(0,1,0, 64,13,  0, 1,0,'h60, 0,0,0,1,1), 103);
        apply(mk(0,1,1, 64, 0,  0, 0,0,'h61, 0,0,0,1,0), 104);
        apply(mk(0,1,1, 32,12,  0, 0,0,'h62, 1,1,1,1,1), 105);
        apply(mk(0,0,0,  0, 0,  0, 0,0,'h00, 0,0,0,1,0), 106);
        check_stats("stats final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
